complex_mat_mul_seq: RTL
========================

COMPLEX_MAT_MUL_SEQ -- requirements
Module: complex_mat_mul_seq

Interface
REQ-001 SHALL have parameter SIZE, default 4: matrix dimension (power of 2, >=2).
REQ-002 SHALL have parameter WIDTH, default 64: IEEE-754 double per real/imag part.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start_i, input, 1 bit: begin computing C = A*B; honoured only in IDLE.
REQ-006 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done_o, output, 1 bit: one-cycle pulse after the last C row handshake.
REQ-008 SHALL have ports a_row_addr_o / b_row_addr_o, output, $clog2(SIZE) bits each: row read address.
REQ-009 SHALL have ports a_row_addr_valid_o / b_row_addr_valid_o, output, 1 bit each: read request strobe.
REQ-010 SHALL have ports a_row_i / b_row_i, input, SIZE*2*WIDTH bits each: row data; element k = bits [k*2W +: 2W], {imag,real}.
REQ-011 SHALL have ports a_row_valid_i / b_row_valid_i, input, 1 bit each, plus b_row_addr_i, input, $clog2(SIZE) bits: echoed address of returned B row.
REQ-012 SHALL have port mul_operands_o, output, SIZE*4*WIDTH bits: slot k*4+0..3 = {A re, A im, B re, B im} of term k.
REQ-013 SHALL have ports mul_in_valid_o (output) / mul_in_ready_i (input), 1 bit each: operand handshake to complex_matrix_mul.
REQ-014 SHALL have ports mul_result_i, input, 2*WIDTH bits {imag,real}; mul_out_valid_i, input, 1 bit; mul_out_ready_o, output, 1 bit.
REQ-015 SHALL have ports c_row_o (output, SIZE*2*WIDTH), c_row_addr_o (output, $clog2(SIZE)), c_row_valid_o (output, 1), c_row_ready_i (input, 1): result row stream.

Function
REQ-016 SHALL implement states IDLE, LOAD_B, FETCH_A, ISSUE, WAIT_RES, EMIT.
REQ-017 IDLE->LOAD_B on start_i; start_i while busy_o SHALL be ignored.
REQ-018 LOAD_B SHALL pulse b_row_addr_valid_o for addresses 0..SIZE-1 on consecutive cycles, store each returned row at b_row_addr_i, and leave after SIZE rows received.
REQ-019 FETCH_A SHALL issue a one-cycle request for row i, hold it in a register on a_row_valid_i, then go to ISSUE with j=0.
REQ-020 ISSUE SHALL present A row i against buffered B column j, hold mul_in_valid_o and operands stable until mul_in_ready_i, then go to WAIT_RES.
REQ-021 WAIT_RES SHALL hold mul_out_ready_o high, write mul_result_i into C element j on mul_out_valid_i; j<SIZE-1 -> ISSUE with j+1, else EMIT.
REQ-022 At most one multiply SHALL be outstanding at any time.
REQ-023 EMIT SHALL hold c_row_valid_o, c_row_o, c_row_addr_o=i stable until c_row_ready_i; then i<SIZE-1 -> FETCH_A with i+1, else IDLE with done_o pulsed.
REQ-024 Counters i, j SHALL not wrap within a job; both clear on entry to LOAD_B.
REQ-025 Data SHALL pass bit-exact; no arithmetic in this block.

Reset
REQ-026 On rst_i SHALL go IDLE immediately, mid-operation included, and discard the job.
REQ-027 Reset value of every output SHALL be 0 (all valids, strobes, busy_o, done_o, addresses, data).
REQ-028 The B buffer SHALL need no reset; the job after reset SHALL reload it.

Structure
REQ-029 Shared package mat_pkg SHALL hold the cplx_t struct {imag,real}, the state enum and SIZE/WIDTH defaults.
REQ-030 The B buffer SHALL be one sub-module, cplx_mat_buf (row write, column read).

Verification
REQ-031 A=I, B=all 2.0+j1.0, ready always 1 -> four C rows all 2.0+j1.0, addresses 0..3, one done_o.
REQ-032 Hold mul_in_ready_i low 5 cycles in ISSUE -> operands and mul_in_valid_o unchanged for those 5 cycles.
REQ-033 c_row_ready_i low 3 cycles on row 2 -> c_row_o and c_row_addr_o=2 stable for those cycles; no new ISSUE.
REQ-034 B rows returned in order 3,0,2,1 -> operand B slots match column j, e.g. slot k*4+2 = B[k][j] real.
REQ-035 rst_i pulsed during WAIT_RES of row 1 -> all outputs 0 the same cycle; a new start_i gives a complete correct job.
REQ-036 start_i pulsed during EMIT -> ignored; exactly four C rows and one done_o.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared types for the sequential complex matrix multiplier: element layout,
// controller state encoding and default dimensions.
package mat_pkg;

  localparam int SIZE_DEF  = 4;
  localparam int WIDTH_DEF = 64;

  // One complex element; the imaginary part occupies the upper half.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] im;
    logic [WIDTH_DEF-1:0] re;
  } cplx_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_B   = 3'd1,
    ST_FETCH_A  = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_EMIT     = 3'd5
  } state_t;

endpackage

// File: rtl/cplx_mat_buf.sv
// SIZE x SIZE complex matrix store: whole rows are written, whole columns are
// read combinationally. Contents are not reset; every job reloads them.
module cplx_mat_buf #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(SIZE),
  localparam int EW   = 2 * WIDTH
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [SIZE*EW-1:0] wr_row,
  input  logic [AW-1:0]      rd_addr,
  output logic [SIZE*EW-1:0] rd_col
);

  logic [EW-1:0] mem [SIZE][SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < SIZE; k++) begin
        mem[wr_addr][k] <= wr_row[k*EW +: EW];
      end
    end
  end

  // Column element k comes from row k of the stored matrix.
  always_comb begin
    rd_col = '0;
    for (int k = 0; k < SIZE; k++) begin
      rd_col[k*EW +: EW] = mem[k][rd_addr];
    end
  end

endmodule

// File: rtl/complex_mat_mul_seq.sv
// Sequencer computing C = A*B one element at a time through an external complex
// multiply-accumulate unit; B is buffered locally, A is fetched row by row.
module complex_mat_mul_seq
  import mat_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int AW   = $clog2(SIZE),
  localparam int EW   = 2 * WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [AW-1:0]         a_row_addr_o,
  output logic                  a_row_addr_valid_o,
  output logic [AW-1:0]         b_row_addr_o,
  output logic                  b_row_addr_valid_o,
  input  logic [SIZE*EW-1:0]    a_row_i,
  input  logic                  a_row_valid_i,
  input  logic [SIZE*EW-1:0]    b_row_i,
  input  logic                  b_row_valid_i,
  input  logic [AW-1:0]         b_row_addr_i,
  output logic [SIZE*4*WIDTH-1:0] mul_operands_o,
  output logic                  mul_in_valid_o,
  input  logic                  mul_in_ready_i,
  input  logic [EW-1:0]         mul_result_i,
  input  logic                  mul_out_valid_i,
  output logic                  mul_out_ready_o,
  output logic [SIZE*EW-1:0]    c_row_o,
  output logic [AW-1:0]         c_row_addr_o,
  output logic                  c_row_valid_o,
  input  logic                  c_row_ready_i,
  output state_t                state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid side holds its data stable until that edge.
  state_t               state_q, state_d;
  logic [AW-1:0]        i_q, j_q;
  logic [AW:0]          b_req_q;
  logic [AW-1:0]        b_rx_q;
  logic                 a_req_sent_q;
  logic [SIZE*EW-1:0]   a_row_q;
  logic [SIZE*EW-1:0]   c_q;
  logic                 done_q;
  logic [SIZE*EW-1:0]   b_col;
  logic                 last_col, last_row;

  assign last_col = (j_q == AW'(SIZE - 1));
  assign last_row = (i_q == AW'(SIZE - 1));

  cplx_mat_buf #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_b_buf (
    .clk     (clk_i),
    .wr_en   (state_q == ST_LOAD_B && b_row_valid_i),
    .wr_addr (b_row_addr_i),
    .wr_row  (b_row_i),
    .rd_addr (j_q),
    .rd_col  (b_col)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_i) state_d = ST_LOAD_B;
      ST_LOAD_B:   if (b_row_valid_i && b_rx_q == AW'(SIZE - 1)) state_d = ST_FETCH_A;
      ST_FETCH_A:  if (a_row_valid_i) state_d = ST_ISSUE;
      ST_ISSUE:    if (mul_in_ready_i) state_d = ST_WAIT_RES;
      ST_WAIT_RES: if (mul_out_valid_i) state_d = last_col ? ST_EMIT : ST_ISSUE;
      ST_EMIT:     if (c_row_ready_i) state_d = last_row ? ST_IDLE : ST_FETCH_A;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      b_req_q      <= '0;
      b_rx_q       <= '0;
      a_req_sent_q <= 1'b0;
      a_row_q      <= '0;
      c_q          <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            i_q     <= '0;
            j_q     <= '0;
            b_req_q <= '0;
            b_rx_q  <= '0;
          end
        end
        ST_LOAD_B: begin
          if (!b_req_q[AW]) b_req_q <= b_req_q + 1'b1;
          if (b_row_valid_i) b_rx_q <= b_rx_q + 1'b1;
        end
        ST_FETCH_A: begin
          if (!a_req_sent_q) a_req_sent_q <= 1'b1;
          if (a_row_valid_i) begin
            a_row_q      <= a_row_i;
            a_req_sent_q <= 1'b0;
            j_q          <= '0;
          end
        end
        ST_WAIT_RES: begin
          if (mul_out_valid_i) begin
            for (int k = 0; k < SIZE; k++) begin
              if (AW'(k) == j_q) c_q[k*EW +: EW] <= mul_result_i;
            end
            if (!last_col) j_q <= j_q + 1'b1;
          end
        end
        ST_EMIT: begin
          if (c_row_ready_i) begin
            if (last_row) done_q <= 1'b1;
            else          i_q    <= i_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Term k pairs A[i][k] with B[k][j]; operands are zero outside ISSUE.
  always_comb begin
    mul_operands_o = '0;
    if (state_q == ST_ISSUE) begin
      for (int k = 0; k < SIZE; k++) begin
        mul_operands_o[(4*k+0)*WIDTH +: WIDTH] = a_row_q[k*EW +: WIDTH];
        mul_operands_o[(4*k+1)*WIDTH +: WIDTH] = a_row_q[k*EW+WIDTH +: WIDTH];
        mul_operands_o[(4*k+2)*WIDTH +: WIDTH] = b_col[k*EW +: WIDTH];
        mul_operands_o[(4*k+3)*WIDTH +: WIDTH] = b_col[k*EW+WIDTH +: WIDTH];
      end
    end
  end

  assign busy_o             = (state_q != ST_IDLE);
  assign done_o             = done_q;
  assign a_row_addr_o       = i_q;
  assign a_row_addr_valid_o = (state_q == ST_FETCH_A) && !a_req_sent_q;
  assign b_row_addr_o       = b_req_q[AW-1:0];
  assign b_row_addr_valid_o = (state_q == ST_LOAD_B) && !b_req_q[AW];
  assign mul_in_valid_o     = (state_q == ST_ISSUE);
  assign mul_out_ready_o    = (state_q == ST_WAIT_RES);
  assign c_row_o            = c_q;
  assign c_row_addr_o       = i_q;
  assign c_row_valid_o      = (state_q == ST_EMIT);
  assign state_o            = state_q;

endmodule
